// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus iterative
// unsigned shift-add MUL and restoring DIV, with registered result and flags.
module alu_seq #(
    parameter int width       = 16,
    parameter int flags_width = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             opcode,
    input  logic [width-1:0]       in1,
    input  logic [width-1:0]       in2,
    input  logic                   carry,
    input  logic                   oe,
    output logic [width-1:0]       out,
    output logic [width-1:0]       out_hi,
    output logic [flags_width-1:0] flags,
    output logic                   busy,
    output logic                   done
);

    localparam int cnt_w = $clog2(width + 1);

    localparam logic [3:0] op_add = 4'h0;
    localparam logic [3:0] op_adc = 4'h1;
    localparam logic [3:0] op_sub = 4'h2;
    localparam logic [3:0] op_sbb = 4'h3;
    localparam logic [3:0] op_and = 4'h4;
    localparam logic [3:0] op_or  = 4'h5;
    localparam logic [3:0] op_xor = 4'h6;
    localparam logic [3:0] op_not = 4'h7;
    localparam logic [3:0] op_shl = 4'h8;
    localparam logic [3:0] op_shr = 4'h9;
    localparam logic [3:0] op_sar = 4'hA;
    localparam logic [3:0] op_rol = 4'hB;
    localparam logic [3:0] op_ror = 4'hC;
    localparam logic [3:0] op_cmp = 4'hD;
    localparam logic [3:0] op_mul = 4'hE;
    localparam logic [3:0] op_div = 4'hF;

    typedef enum logic [0:0] {
        st_idle = 1'b0,
        st_iter = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [width-1:0] result;
    logic [width-1:0] result_hi;
    logic [4:0]       flags_q;
    logic             done_q;

    // Iteration registers: acc_hi is partial product high / remainder,
    // acc_lo is multiplier-then-product low / dividend-then-quotient.
    logic [width-1:0] acc_hi;
    logic [width-1:0] acc_lo;
    logic [width-1:0] operand_b;
    logic             is_div;
    logic [cnt_w-1:0] cnt;
    logic             last_iter;

    logic [width:0]   alu_ext;
    logic [width-1:0] alu_lo;
    logic             alu_c;
    logic             alu_o;

    logic [width:0]   mul_sum;
    logic [width-1:0] mul_hi_next;
    logic [width-1:0] mul_lo_next;
    logic [width:0]   div_shifted;
    logic [width:0]   div_trial;
    logic [width-1:0] div_hi_next;
    logic [width-1:0] div_lo_next;
    logic [width-1:0] iter_hi_next;
    logic [width-1:0] iter_lo_next;

    logic             accept;
    logic             div_by_zero;

    // Flags packed as {P,S,Z,O,C}; P/S/Z always come from the low word.
    function automatic logic [4:0] make_flags(input logic [width-1:0] lo,
                                              input logic o, input logic c);
        make_flags = {~^lo, lo[width-1], (lo == '0), o, c};
    endfunction

    assign accept      = start && (state == st_idle);
    assign div_by_zero = (in2 == '0);
    assign last_iter   = (cnt == cnt_w'(width - 1));

    // Single-cycle datapath, evaluated on the operands present at the start edge.
    always_comb begin
        alu_ext = '0;
        alu_lo  = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        case (opcode)
            op_add, op_adc: begin
                alu_ext = {1'b0, in1} + {1'b0, in2}
                        + {{width{1'b0}}, (opcode == op_adc) ? carry : 1'b0};
                alu_lo  = alu_ext[width-1:0];
                alu_c   = alu_ext[width];
                alu_o   = (in1[width-1] == in2[width-1]) && (alu_lo[width-1] != in1[width-1]);
            end
            op_sub, op_sbb, op_cmp: begin
                alu_ext = {1'b0, in1} - {1'b0, in2}
                        - {{width{1'b0}}, (opcode == op_sbb) ? carry : 1'b0};
                alu_lo  = alu_ext[width-1:0];
                alu_c   = alu_ext[width];
                alu_o   = (in1[width-1] != in2[width-1]) && (alu_lo[width-1] != in1[width-1]);
            end
            op_and: alu_lo = in1 & in2;
            op_or:  alu_lo = in1 | in2;
            op_xor: alu_lo = in1 ^ in2;
            op_not: alu_lo = ~in1;
            op_shl: begin
                alu_lo = {in1[width-2:0], 1'b0};
                alu_c  = in1[width-1];
            end
            op_shr: begin
                alu_lo = {1'b0, in1[width-1:1]};
                alu_c  = in1[0];
            end
            op_sar: begin
                alu_lo = {in1[width-1], in1[width-1:1]};
                alu_c  = in1[0];
            end
            op_rol: begin
                alu_lo = {in1[width-2:0], in1[width-1]};
                alu_c  = in1[width-1];
            end
            op_ror: begin
                alu_lo = {in1[0], in1[width-1:1]};
                alu_c  = in1[0];
            end
            default: begin
                alu_lo = '0;
            end
        endcase
    end

    // One iteration step of shift-add multiply and restoring divide.
    always_comb begin
        mul_sum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
        mul_hi_next  = mul_sum[width:1];
        mul_lo_next  = {mul_sum[0], acc_lo[width-1:1]};

        div_shifted  = {acc_hi, acc_lo[width-1]};
        div_trial    = div_shifted - {1'b0, operand_b};
        div_hi_next  = div_shifted[width-1:0];
        div_lo_next  = {acc_lo[width-2:0], 1'b0};
        if (!div_trial[width]) begin
            div_hi_next = div_trial[width-1:0];
            div_lo_next = {acc_lo[width-2:0], 1'b1};
        end

        iter_hi_next = is_div ? div_hi_next : mul_hi_next;
        iter_lo_next = is_div ? div_lo_next : mul_lo_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= st_idle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            st_idle: begin
                if (accept && (opcode == op_mul || (opcode == op_div && !div_by_zero))) begin
                    state_next = st_iter;
                end
            end
            st_iter: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = st_idle;
                end
            end
            default: state_next = st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            result_hi <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            operand_b <= '0;
            is_div    <= 1'b0;
            cnt       <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                case (opcode)
                    op_mul, op_div: begin
                        if (opcode == op_div && div_by_zero) begin
                            result    <= '1;
                            result_hi <= in1;
                            flags_q   <= make_flags('1, 1'b0, 1'b1);
                            done_q    <= 1'b1;
                        end else begin
                            acc_hi    <= '0;
                            acc_lo    <= in1;
                            operand_b <= in2;
                            is_div    <= (opcode == op_div);
                            cnt       <= '0;
                        end
                    end
                    op_cmp: begin
                        flags_q <= make_flags(alu_lo, alu_o, alu_c);
                        done_q  <= 1'b1;
                    end
                    default: begin
                        result    <= alu_lo;
                        result_hi <= '0;
                        flags_q   <= make_flags(alu_lo, alu_o, alu_c);
                        done_q    <= 1'b1;
                    end
                endcase
            end else if (state == st_iter) begin
                acc_hi <= iter_hi_next;
                acc_lo <= iter_lo_next;
                if (last_iter) begin
                    // Final step commits straight into the visible registers.
                    result    <= iter_lo_next;
                    result_hi <= iter_hi_next;
                    flags_q   <= is_div ? make_flags(iter_lo_next, 1'b0, 1'b0)
                                        : make_flags(iter_lo_next, (iter_hi_next != '0),
                                                     (iter_hi_next != '0));
                    done_q    <= 1'b1;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign out    = oe ? result : {width{1'bz}};
    assign out_hi = result_hi;
    assign flags  = flags_width'(flags_q);
    assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at width 16 with hand-computed results.
module tb_alu_seq;

    localparam int width = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [3:0]       opcode;
    logic [width-1:0] in1;
    logic [width-1:0] in2;
    logic             carry;
    logic             oe;
    wire  [width-1:0] out;
    logic [width-1:0] out_hi;
    logic [4:0]       flags;
    logic             busy;
    logic             done;

    int errors;
    int checks;

    alu_seq #(.width(width), .flags_width(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opcode (opcode),
        .in1    (in1),
        .in2    (in2),
        .carry  (carry),
        .oe     (oe),
        .out    (out),
        .out_hi (out_hi),
        .flags  (flags),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation; returns 1ns after the start edge.
    task automatic do_start(input logic [3:0] op, input logic [width-1:0] a,
                            input logic [width-1:0] b, input logic cin);
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        in1    = a;
        in2    = b;
        carry  = cin;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_single(input string tag, input logic [width-1:0] exp_out,
                                input logic [4:0] exp_flags);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_out"}, 32'(out), 32'(exp_out));
        check({tag, "_hi"}, 32'(out_hi), 32'd0);
        check({tag, "_flags"}, 32'(flags), 32'(exp_flags));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 40);
    endtask

    int n;
    int done_seen;

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        start  = 1'b0;
        opcode = '0;
        in1    = '0;
        in2    = '0;
        carry  = 1'b0;
        oe     = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_hi", 32'(out_hi), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ADD overflow into the sign bit
        do_start(4'h0, 16'h7FFF, 16'h0001, 1'b0);
        check_single("add", 16'h8000, 5'b01010);
        check("add_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("add_done_drop", 32'(done), 32'd0);

        // CMP leaves result alone
        do_start(4'hD, 16'h0005, 16'h0005, 1'b0);
        check("cmp_done", 32'(done), 32'd1);
        check("cmp_flags", 32'(flags), 32'(5'b10100));
        check("cmp_out", 32'(out), 32'h8000);

        @(negedge clk);
        oe = 1'b0;
        #1;
        check("oe_off_released", 32'(out !== 16'h8000), 32'd1);
        check("oe_off_flags", 32'(flags), 32'(5'b10100));
        @(negedge clk);
        oe = 1'b1;
        #1;
        check("oe_on_out", 32'(out), 32'h8000);

        // Back-to-back single-cycle ops: each start lands while the previous done is high
        do_start(4'h2, 16'h0000, 16'h0001, 1'b0);
        check_single("sub_borrow", 16'hFFFF, 5'b11001);
        do_start(4'h3, 16'h0005, 16'h0003, 1'b1);
        check_single("sbb", 16'h0001, 5'b00000);
        do_start(4'h2, 16'h8000, 16'h0001, 1'b0);
        check_single("sub_ovf", 16'h7FFF, 5'b00010);
        do_start(4'h1, 16'hFFFF, 16'h0000, 1'b1);
        check_single("adc", 16'h0000, 5'b10101);
        do_start(4'h4, 16'hF0F0, 16'hFF00, 1'b0);
        check_single("and", 16'hF000, 5'b11000);
        do_start(4'h5, 16'h00F0, 16'h000F, 1'b0);
        check_single("or", 16'h00FF, 5'b10000);
        do_start(4'h6, 16'hFFFF, 16'hFFFF, 1'b0);
        check_single("xor", 16'h0000, 5'b10100);
        do_start(4'h7, 16'h00FF, 16'h1234, 1'b0);
        check_single("not", 16'hFF00, 5'b11000);
        do_start(4'h8, 16'h8001, 16'h0000, 1'b0);
        check_single("shl", 16'h0002, 5'b00001);
        do_start(4'h9, 16'h8001, 16'h0000, 1'b0);
        check_single("shr", 16'h4000, 5'b00001);
        do_start(4'hA, 16'h8001, 16'h0000, 1'b0);
        check_single("sar", 16'hC000, 5'b11001);
        do_start(4'hB, 16'h8001, 16'h0000, 1'b0);
        check_single("rol", 16'h0003, 5'b10001);
        do_start(4'hC, 16'h8001, 16'h0000, 1'b0);
        check_single("ror", 16'hC000, 5'b11001);

        // MUL with operand churn and ignored starts while busy
        do_start(4'hE, 16'h1234, 16'h0100, 1'b0);
        in1 = 16'hFFFF;
        in2 = 16'hFFFF;
        check("mul_busy0", 32'(busy), 32'd1);
        check("mul_done0", 32'(done), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 3 || i == 8) begin
                start  = 1'b1;
                opcode = 4'h0;
                in1    = 16'h0001;
                in2    = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i < 16) begin
                if (!busy || done || flags !== 5'b11001) begin
                    check("mul_busy_phase", {busy, done, 25'd0, flags}, {1'b1, 1'b0, 25'd0, 5'b11001});
                end
            end
        end
        start = 1'b0;
        check("mul_done", 32'(done), 32'd1);
        check("mul_busy_fall", 32'(busy), 32'd0);
        check("mul_out", 32'(out), 32'h3400);
        check("mul_hi", 32'(out_hi), 32'h0012);
        check("mul_flags", 32'(flags), 32'(5'b00011));
        @(posedge clk);
        #1;
        check("mul_no_extra_done", 32'(done), 32'd0);

        do_start(4'hE, 16'h00FF, 16'h0002, 1'b0);
        wait_done(n);
        check("mul2_latency", 32'(n), 32'd16);
        check("mul2_out", 32'(out), 32'h01FE);
        check("mul2_hi", 32'(out_hi), 32'h0000);
        check("mul2_flags", 32'(flags), 32'(5'b10000));

        // DIV
        do_start(4'hF, 16'h0064, 16'h0007, 1'b0);
        check("div_busy0", 32'(busy), 32'd1);
        wait_done(n);
        check("div_latency", 32'(n), 32'd16);
        check("div_out", 32'(out), 32'h000E);
        check("div_hi", 32'(out_hi), 32'h0002);
        check("div_flags", 32'(flags), 32'(5'b00000));

        do_start(4'hF, 16'hFFFF, 16'h0001, 1'b0);
        wait_done(n);
        check("div1_latency", 32'(n), 32'd16);
        check("div1_out", 32'(out), 32'hFFFF);
        check("div1_hi", 32'(out_hi), 32'h0000);
        check("div1_flags", 32'(flags), 32'(5'b11000));

        do_start(4'hF, 16'h1234, 16'h0000, 1'b0);
        check("div0_done", 32'(done), 32'd1);
        check("div0_busy", 32'(busy), 32'd0);
        check("div0_out", 32'(out), 32'hFFFF);
        check("div0_hi", 32'(out_hi), 32'h1234);
        check("div0_flags", 32'(flags), 32'(5'b11001));

        // Reset during MUL aborts without a done pulse
        do_start(4'hE, 16'h1234, 16'h0100, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_out", 32'(out), 32'd0);
        check("abort_hi", 32'(out_hi), 32'd0);
        check("abort_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
